sd_image_loader: RTL
====================

// Module: sd_image_loader
// PURPOSE
//  Downstream stage of the SD-SPI sector reader; together they copy the Linux image from microSD to RAM at boot.
//  Sequences the reader through NUM_SECTORS consecutive sectors via its rstart/rsector/rdone handshake.
//  Packs the reader's byte stream (outen/outaddr/outbyte) into little-endian 32-bit words.
//  Writes the words to RAM through a valid/ready port and holds the CPU in reset until the copy completes.
// PARAMETERS
//  START_SECTOR  32'd0         first SD sector (LBA) to read
//  NUM_SECTORS   32'd16384     sectors to copy (default 8 MiB); must be >= 1
//  RAM_BASE      32'h8000_0000 RAM byte address receiving byte 0 of START_SECTOR
//  FIFO_DEPTH    4             word FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  start       in   1   begin copy; sampled only in IDLE
//  busy        out  1   copy in progress (IDLE/DONE/ERR -> 0)
//  done        out  1   sticky; copy finished and all words accepted by RAM
//  error       out  1   sticky; protocol violation or FIFO overflow
//  cpu_hold    out  1   1 from reset until done; stays 1 on error
//  sect_cnt    out  32  sectors fully received so far
//  rstart      out  1   to reader: read request
//  rsector     out  32  to reader: sector LBA; stable while rstart=1
//  rbusy       in   1   from reader (status only; not used for control)
//  rdone       in   1   from reader: 1-cycle pulse, sector finished
//  outen       in   1   from reader: byte strobe
//  outaddr     in   9   from reader: byte index 0..511
//  outbyte     in   8   from reader: byte value
//  mem_valid   out  1   RAM write request
//  mem_addr    out  32  RAM byte address, word-aligned
//  mem_wdata   out  32  write data, byte k of word at bits [8k+7:8k]
//  mem_ready   in   1   RAM accepts when mem_valid && mem_ready
// BEHAVIOUR
//  Reset: rstart=0, rsector=START_SECTOR, mem_valid=0, mem_addr=RAM_BASE, mem_wdata=0, busy=0, done=0,
//   error=0, cpu_hold=1, sect_cnt=0. FIFO is emptied and the packer is cleared. Reset mid-copy aborts
//   immediately. Reader-side state is the reader's concern; there is no need to drain it.
//  FSM:
//   IDLE  -> REQ on start. Load rsector=START_SECTOR and idx=0.
//   REQ   rstart=1, held until rdone is seen. On rdone -> GAP.
//   GAP   rstart=0 for exactly one cycle; the reader requires the low gap.
//         If idx+1==NUM_SECTORS -> DRAIN; else idx++, rsector++, -> REQ.
//   DRAIN wait until FIFO is empty and no write is pending -> DONE.
//   DONE  done=1, cpu_hold=0, busy=0; a new start is ignored until rst.
//   ERR   rstart=0; packer and FIFO frozen, mem_valid=0; terminal until rst.
//  Byte packing (REQ only; outen outside REQ -> ERR):
//   - Expected byte counter bcnt runs 0..511. outaddr!=bcnt on outen -> ERR.
//   - Byte lane outaddr[1:0] goes into the shift word.
//   - On lane 3 the word is pushed to the FIFO with
//     addr = RAM_BASE + {idx,9'b0} + {outaddr[8:2],2'b00}.
//   - rdone with bcnt!=512 -> ERR. The rdone check takes priority over a same-cycle outen.
//   - sect_cnt increments on a valid rdone.
//  FIFO / RAM:
//   - The reader has no backpressure. A push into a full FIFO -> ERR (overflow, sticky error).
//   - Simultaneous push and pop when full is legal, not an overflow.
//   - FIFO head drives mem_valid/mem_addr/mem_wdata. Pop on mem_valid && mem_ready.
//   - mem_* hold stable while mem_valid && !mem_ready.
//   - Zero-latency head: a word pushed in cycle N can be presented in cycle N+1.
//  Address arithmetic is 32-bit modulo 2^32. Wrap is not flagged.
// STRUCTURE
//  Shared package `define.vh`: state encodings (LDR_IDLE..LDR_ERR) and SDSPI_BLOCKSIZE (512).
//  Sub-module: sd_word_fifo, a synchronous FIFO of {addr[31:0],data[31:0]} x FIFO_DEPTH,
//   with full/empty and pointer wrap by extra MSB.
//  Top: FSM, byte packer, counters.
// TESTING
//  1. NUM_SECTORS=2, START_SECTOR=100, reader model emits bytes 0..511 = addr[7:0] every 4 clk.
//     Required: rsector=100 then 101; 256 writes; first word 0x03020100 @RAM_BASE;
//     word @RAM_BASE+0x200 = 0x03020100; done=1, cpu_hold=0, sect_cnt=2.
//  2. mem_ready low 3 of every 4 cycles, FIFO_DEPTH=4.
//     Required: no error; data identical to case 1; done asserts only after the last write is accepted.
//  3. mem_ready held 0 for 40 cycles mid-sector.
//     Required: error=1 on the 5th queued word, rstart=0, busy=0, done never asserts.
//  4. Reader skips outaddr 17.
//     Required: error=1 on the cycle after outaddr=18 is strobed; no further mem_valid.
//  5. rdone after only 508 bytes -> error=1, sect_cnt unchanged.
//  6. rst asserted in REQ mid-sector.
//     Required: next cycle all outputs at reset values; start restarts from START_SECTOR.

Source files
------------

// File: rtl/sd_image_loader_pkg.sv
// Shared definitions for the SD boot image loader: FSM states and block size.
package sd_image_loader_pkg;

    localparam int SDSPI_BLOCKSIZE = 512;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_REQ,
        LDR_GAP,
        LDR_DRAIN,
        LDR_DONE,
        LDR_ERR
    } ldr_state_t;

endpackage

// File: rtl/sd_word_fifo.sv
// Small synchronous FIFO of {addr,data} write entries with a combinational head,
// so a word pushed in one cycle is visible at the output the next cycle.
module sd_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] din,
    input  logic        pop,
    output logic [63:0] head,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0] mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sd_image_loader.sv
// Boot-time copier: walks the SD reader through consecutive sectors, packs the
// byte stream into little-endian words and writes them to RAM, holding the CPU
// in reset until every word has been accepted.
module sd_image_loader
    import sd_image_loader_pkg::*;
#(
    parameter logic [31:0] START_SECTOR = 32'd0,
    parameter logic [31:0] NUM_SECTORS  = 32'd16384,
    parameter logic [31:0] RAM_BASE     = 32'h8000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [31:0] sect_cnt,
    output logic        rstart,
    output logic [31:0] rsector,
    input  logic        rbusy,
    input  logic        rdone,
    input  logic        outen,
    input  logic [8:0]  outaddr,
    input  logic [7:0]  outbyte,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready
);
    ldr_state_t  state_reg, state_next;
    logic [31:0] idx_reg;
    logic [31:0] rsector_reg;
    logic [31:0] sect_cnt_reg;
    logic [9:0]  bcnt_reg;
    logic [23:0] word_reg;

    logic        byte_ok;
    logic        rdone_ok;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] head;
    logic [31:0] push_addr;
    logic [31:0] push_data;

    // The reader's busy flag is informational only.
    logic unused_rbusy;
    assign unused_rbusy = rbusy;

    assign push_addr = RAM_BASE + {idx_reg[22:0], 9'b0} + {23'b0, outaddr[8:2], 2'b00};
    assign push_data = {outbyte, word_reg};

    assign mem_valid = !fifo_empty && (state_reg != LDR_ERR);
    assign pop       = mem_valid && mem_ready;
    assign mem_addr  = mem_valid ? head[63:32] : RAM_BASE;
    assign mem_wdata = mem_valid ? head[31:0]  : 32'd0;
    assign rsector   = rsector_reg;
    assign sect_cnt  = sect_cnt_reg;

    sd_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({push_addr, push_data}),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= LDR_IDLE;
        else     state_reg <= state_next;
    end

    // Next state, byte acceptance, protocol checks and status decode.
    always_comb begin
        state_next = state_reg;
        byte_ok    = 1'b0;
        rdone_ok   = 1'b0;
        push       = 1'b0;
        rstart     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        case (state_reg)
            LDR_IDLE: begin
                if (start) state_next = LDR_REQ;
            end
            LDR_REQ: begin
                rstart = 1'b1;
                busy   = 1'b1;
                // A short sector outranks anything about a same-cycle byte.
                if (rdone && (bcnt_reg != 10'(SDSPI_BLOCKSIZE))) begin
                    state_next = LDR_ERR;
                end else if (outen && ({1'b0, outaddr} != bcnt_reg)) begin
                    state_next = LDR_ERR;
                end else if (outen && (outaddr[1:0] == 2'd3) && fifo_full && !pop) begin
                    state_next = LDR_ERR;
                end else begin
                    byte_ok = outen;
                    push    = outen && (outaddr[1:0] == 2'd3);
                    if (rdone) begin
                        rdone_ok   = 1'b1;
                        state_next = LDR_GAP;
                    end
                end
            end
            LDR_GAP: begin
                busy = 1'b1;
                if (outen)                              state_next = LDR_ERR;
                else if (idx_reg + 32'd1 == NUM_SECTORS) state_next = LDR_DRAIN;
                else                                    state_next = LDR_REQ;
            end
            LDR_DRAIN: begin
                busy = 1'b1;
                if (outen)           state_next = LDR_ERR;
                else if (fifo_empty) state_next = LDR_DONE;
            end
            LDR_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            LDR_ERR: begin
                error = 1'b1;
            end
            default: state_next = LDR_ERR;
        endcase
    end

    // Sector sequencing, byte counter, partial word and received-sector count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg      <= 32'd0;
            rsector_reg  <= START_SECTOR;
            sect_cnt_reg <= 32'd0;
            bcnt_reg     <= 10'd0;
            word_reg     <= 24'd0;
        end else begin
            if (state_reg == LDR_IDLE && state_next == LDR_REQ) begin
                idx_reg     <= 32'd0;
                rsector_reg <= START_SECTOR;
                bcnt_reg    <= 10'd0;
            end
            if (state_reg == LDR_GAP && state_next == LDR_REQ) begin
                idx_reg     <= idx_reg + 32'd1;
                rsector_reg <= rsector_reg + 32'd1;
                bcnt_reg    <= 10'd0;
            end
            if (byte_ok) begin
                bcnt_reg <= bcnt_reg + 10'd1;
                case (outaddr[1:0])
                    2'd0:    word_reg[7:0]   <= outbyte;
                    2'd1:    word_reg[15:8]  <= outbyte;
                    2'd2:    word_reg[23:16] <= outbyte;
                    default: word_reg        <= word_reg;
                endcase
            end
            if (rdone_ok) sect_cnt_reg <= sect_cnt_reg + 32'd1;
        end
    end

endmodule
